// File: rtl/fetch_controller.sv
`default_nettype none
// ============================================================================
// Module      : fetch_controller
// Description : Single-outstanding instruction fetch sequencer with a
//               one-entry hold buffer, decode backpressure and redirect flush.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_controller #(
    parameter int               XLEN = 64,
    parameter int               ILEN = 32,
    parameter logic [ILEN-1:0]  NOP  = 32'h00000013
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [XLEN-1:0]   pc_in,
    output logic              pc_stall,
    input  logic              redirect,
    input  logic              id_stall,
    output logic              imem_req,
    output logic [XLEN-1:0]   imem_addr,
    input  logic              imem_ready,
    input  logic              imem_rvalid,
    input  logic [ILEN-1:0]   imem_rdata,
    output logic [ILEN-1:0]   instr_out,
    output logic [XLEN-1:0]   instr_pc,
    output logic              instr_valid,
    output logic [31:0]       fetch_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic               r_drop;
    logic               w_drop_next;
    logic [ILEN-1:0]    r_hold_data;
    logic [XLEN-1:0]    r_req_addr;
    logic               w_load;
    logic [ILEN-1:0]    w_load_data;
    logic               w_hold_wr;
    logic               w_free;
    logic               w_handshake;

    assign w_free      = !instr_valid || !id_stall;
    assign imem_req    = (r_state == ST_REQ);
    assign imem_addr   = imem_req ? pc_in : r_req_addr;
    assign w_handshake = imem_req && imem_ready;

    always_comb begin
        w_next_state = r_state;
        w_drop_next  = r_drop;
        w_load       = 1'b0;
        w_load_data  = r_hold_data;
        w_hold_wr    = 1'b0;
        pc_stall     = 1'b1;
        case (r_state)
            ST_IDLE: w_next_state = ST_REQ;
            ST_REQ: begin
                // A redirect during the handshake cycle poisons the response.
                if (w_handshake) begin
                    w_next_state = ST_WAIT;
                    w_drop_next  = redirect;
                end
            end
            ST_WAIT: begin
                if (imem_rvalid) begin
                    if (r_drop || redirect) begin
                        w_next_state = ST_REQ;
                        w_drop_next  = 1'b0;
                    end else if (w_free) begin
                        w_load       = 1'b1;
                        w_load_data  = imem_rdata;
                        pc_stall     = 1'b0;
                        w_next_state = ST_REQ;
                    end else begin
                        w_hold_wr    = 1'b1;
                        w_next_state = ST_HOLD;
                    end
                end else if (redirect) begin
                    w_drop_next = 1'b1;
                end
            end
            ST_HOLD: begin
                if (redirect) begin
                    w_next_state = ST_REQ;
                end else if (w_free) begin
                    w_load       = 1'b1;
                    w_load_data  = r_hold_data;
                    pc_stall     = 1'b0;
                    w_next_state = ST_REQ;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
        // The PC register must take the redirect target this cycle.
        if (redirect) begin
            pc_stall = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_drop      <= 1'b0;
            r_hold_data <= '0;
            r_req_addr  <= '0;
        end else begin
            r_state <= w_next_state;
            r_drop  <= w_drop_next;
            if (w_handshake) begin
                r_req_addr <= pc_in;
            end
            if (w_hold_wr) begin
                r_hold_data <= imem_rdata;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_out   <= NOP;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
            fetch_count <= '0;
        end else begin
            if (instr_valid && !id_stall && !redirect) begin
                fetch_count <= fetch_count + 32'd1;
            end
            if (redirect) begin
                instr_valid <= 1'b0;
            end else if (w_load) begin
                instr_out   <= w_load_data;
                instr_pc    <= r_req_addr;
                instr_valid <= 1'b1;
            end else if (instr_valid && !id_stall) begin
                instr_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_controller
// Description : Randomized bench for fetch_controller against a queue-based
//               transaction model of in-flight requests and the hold buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_controller;

    localparam int          XLEN = 64;
    localparam int          ILEN = 32;
    localparam logic [31:0] NOP  = 32'h00000013;

    logic              clk = 1'b0;
    logic              reset;
    logic [XLEN-1:0]   pc_in;
    logic              pc_stall;
    logic              redirect;
    logic              id_stall;
    logic              imem_req;
    logic [XLEN-1:0]   imem_addr;
    logic              imem_ready;
    logic              imem_rvalid;
    logic [ILEN-1:0]   imem_rdata;
    logic [ILEN-1:0]   instr_out;
    logic [XLEN-1:0]   instr_pc;
    logic              instr_valid;
    logic [31:0]       fetch_count;

    fetch_controller #(
        .XLEN (XLEN),
        .ILEN (ILEN),
        .NOP  (NOP)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pc_in       (pc_in),
        .pc_stall    (pc_stall),
        .redirect    (redirect),
        .id_stall    (id_stall),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instr_out   (instr_out),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .fetch_count (fetch_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Transaction-level model: an accepted request in flight, a parked response,
    // and the delivered-instruction register seen by decode.
    typedef struct {
        logic [63:0] addr;
        logic        drop;
    } flight_t;

    typedef struct {
        logic [31:0] data;
        logic [63:0] addr;
    } held_t;

    flight_t     inflight[$];
    held_t       held[$];
    bit          m_started;
    bit          m_valid;
    logic [31:0] m_instr;
    logic [63:0] m_pc;
    logic [31:0] m_count;

    function automatic void model_reset();
        inflight.delete();
        held.delete();
        m_started = 1'b0;
        m_valid   = 1'b0;
        m_instr   = NOP;
        m_pc      = '0;
        m_count   = '0;
    endfunction

    task automatic run_cycle(input int p_ready, input int p_rvalid, input int p_stall,
                             input int p_redir, input int p_reset);
        bit          exp_req;
        bit          exp_stall;
        bit          deliver;
        bit          free;
        bit          consumed;
        logic [31:0] d_data;
        logic [63:0] d_addr;
        logic [63:0] target;
        flight_t     f;
        held_t       h;

        reset       = ($urandom_range(99) < p_reset);
        redirect    = !reset && ($urandom_range(99) < p_redir);
        id_stall    = ($urandom_range(99) < p_stall);
        imem_ready  = ($urandom_range(99) < p_ready);
        imem_rvalid = ($urandom_range(99) < p_rvalid);
        imem_rdata  = $urandom;
        target      = {52'd0, $urandom_range(1023), 2'b00};
        if (reset) model_reset();
        #3;

        check("instr_valid", instr_valid, m_valid);
        check("instr_out",   instr_out,   m_instr);
        check("instr_pc",    instr_pc,    m_pc);
        check("fetch_count", fetch_count, m_count);

        deliver  = 1'b0;
        d_data   = '0;
        d_addr   = '0;
        free     = !m_valid || !id_stall;
        consumed = m_valid && !id_stall;
        exp_req  = 1'b0;
        if (reset) begin
            exp_stall = 1'b1;
        end else begin
            exp_req = m_started && inflight.size() == 0 && held.size() == 0;
            if (!m_started) begin
                m_started = 1'b1;
            end else if (exp_req) begin
                if (imem_ready) inflight.push_back('{addr: pc_in, drop: redirect});
            end else if (inflight.size() != 0) begin
                if (imem_rvalid) begin
                    f = inflight.pop_front();
                    if (!(f.drop || redirect)) begin
                        if (free) begin
                            deliver = 1'b1;
                            d_data  = imem_rdata;
                            d_addr  = f.addr;
                        end else begin
                            held.push_back('{data: imem_rdata, addr: f.addr});
                        end
                    end
                end else if (redirect) begin
                    inflight[0].drop = 1'b1;
                end
            end else begin
                if (redirect) begin
                    void'(held.pop_front());
                end else if (free) begin
                    h       = held.pop_front();
                    deliver = 1'b1;
                    d_data  = h.data;
                    d_addr  = h.addr;
                end
            end
            exp_stall = !(redirect || deliver);
        end

        check("imem_req", imem_req, exp_req);
        if (exp_req) check("imem_addr", imem_addr, pc_in);
        check("pc_stall", pc_stall, exp_stall);

        if (!reset) begin
            if (consumed && !redirect) m_count = m_count + 32'd1;
            if (redirect) begin
                m_valid = 1'b0;
            end else if (deliver) begin
                m_valid = 1'b1;
                m_instr = d_data;
                m_pc    = d_addr;
            end else if (consumed) begin
                m_valid = 1'b0;
            end
        end

        @(posedge clk);
        #1;
        if (!reset) begin
            if (redirect)        pc_in = target;
            else if (!exp_stall) pc_in = pc_in + 64'd4;
        end
    endtask

    initial begin
        reset       = 1'b1;
        pc_in       = '0;
        redirect    = 1'b0;
        id_stall    = 1'b0;
        imem_ready  = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        // Reset values, then a clean zero-wait stream from pc 0.
        run_cycle(100, 100, 0, 0, 100);
        for (int i = 0; i < 60; i++)  run_cycle(100, 100, 0, 0, 0);
        // Memory backpressure and sparse redirects.
        for (int i = 0; i < 600; i++) run_cycle(40, 50, 30, 8, 0);
        // Heavy decode stall so responses park in the hold buffer.
        for (int i = 0; i < 600; i++) run_cycle(70, 40, 75, 5, 0);
        // Everything mixed, including asynchronous resets mid-operation.
        for (int i = 0; i < 800; i++) run_cycle(60, 50, 40, 6, 2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
